segment_scheduler: RTL

Timing and fetch scheduler for the LED driver datapath. It sequences one display segment: a blanking window, then nine 49-cycle bit groups, each made of 48 data cycles and one skip cycle. Each data cycle is colour-interleaved B,G,R. In parallel it prefetches each bit group's word from the framebuffer over a req/ack handshake. It sits between the framebuffer read port and the driver main controller, and it supplies the `sync`, blanking and data-enable strobes the controller consumes.

---
 rtl/segment_scheduler_pkg.sv | 39 +++
 rtl/segment_fetch_ctrl.sv | 125 ++++++++++++
 rtl/segment_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/segment_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : segment_scheduler_pkg
// Description : Shared types and constants for the LED driver segment
//               scheduler: FSM state encoding, colour encodings, default
//               timing constants and the segment-length derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package segment_scheduler_pkg;

    // Segment sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_SKIP   = 2'd3
    } state_t;

    // Colour interleave order within a data triplet
    typedef enum logic [1:0] {
        COLOR_B = 2'd0,
        COLOR_G = 2'd1,
        COLOR_R = 2'd2
    } color_t;

    localparam int unsigned c_DEF_BLANKING_CYCLES = 72;
    localparam int unsigned c_DEF_GROUP_LEN       = 48;
    localparam int unsigned c_DEF_GROUPS          = 9;
    localparam int unsigned c_DEF_MUL_COUNT       = 8;

    // Blanking window plus one skip cycle after every bit group
    function automatic int unsigned seg_len(input int unsigned blanking,
                                            input int unsigned group_len,
                                            input int unsigned groups);
        return blanking + groups * (group_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/segment_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : segment_fetch_ctrl
// Description : Framebuffer prefetch engine. Owns the rd_req/rd_ack
//               handshake, a one-entry deferred-request slot used while an
//               earlier fetch is still outstanding, and the underflow
//               detector.
// Ports       : clk_33, rst        - clock, synchronous active-high reset
//               i_flush            - drop all fetch state (scheduler idling)
//               i_issue/i_issue_addr - request a fetch of {row, group}
//               i_start/i_start_grp  - a bit group begins its data cycles
//               i_rd_ack           - framebuffer accepts the request
//               o_rd_req/o_rd_addr - request and address to the framebuffer
//               o_underflow        - sticky: a group started unfetched
// Config      : SEGMENT_SCHEDULER_UNDERFLOW_EN builds the underflow detector;
//               otherwise o_underflow is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module segment_fetch_ctrl #(
    parameter int unsigned ROW_W = 3,
    parameter int unsigned GRP_W = 4
) (
    input  logic                   clk_33,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_issue,
    input  logic [ROW_W+GRP_W-1:0] i_issue_addr,
    input  logic                   i_start,
    input  logic [GRP_W-1:0]       i_start_grp,
    input  logic                   i_rd_ack,
    output logic                   o_rd_req,
    output logic [ROW_W+GRP_W-1:0] o_rd_addr,
    output logic                   o_underflow
);

    localparam int unsigned c_ADDR_W = ROW_W + GRP_W;

    logic                r_req;
    logic [c_ADDR_W-1:0] r_addr;
    logic                r_def_vld;
    logic [c_ADDR_W-1:0] r_def_addr;
    logic                w_hs;

    assign w_hs = r_req & i_rd_ack;

    // A request only goes straight onto the bus when nothing is outstanding
    // and nothing is already waiting; otherwise it waits in the deferred
    // slot. A deferred request launches once rd_req has dropped, so rd_req
    // always shows at least one low cycle after each accepted transfer.
    // Should the schedule outrun the framebuffer by more than one fetch, the
    // newest request replaces the waiting one: the skipped group has already
    // missed its slot.
    always_ff @(posedge clk_33) begin
        if (rst || i_flush) begin
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_def_vld  <= 1'b0;
            r_def_addr <= '0;
        end else begin
            if (w_hs) begin
                r_req <= 1'b0;
            end
            if (!r_req && r_def_vld) begin
                r_req     <= 1'b1;
                r_addr    <= r_def_addr;
                r_def_vld <= 1'b0;
            end
            if (i_issue) begin
                if (!r_req && !r_def_vld) begin
                    r_req  <= 1'b1;
                    r_addr <= i_issue_addr;
                end else begin
                    r_def_vld  <= 1'b1;
                    r_def_addr <= i_issue_addr;
                end
            end
        end
    end

    assign o_rd_req  = r_req;
    assign o_rd_addr = r_addr;

`ifdef SEGMENT_SCHEDULER_UNDERFLOW_EN
    // One completion flag per group slot. Issuing a fetch clears its flag so
    // a completion left over from the previous segment is never trusted.
    logic [(2**GRP_W)-1:0] r_done;
    logic                  r_underflow;
    logic                  w_grp_ready;

    // A transfer accepted on the very edge the group starts counts as in time.
    assign w_grp_ready = r_done[i_start_grp] ||
                         (w_hs && (r_addr[GRP_W-1:0] == i_start_grp));

    always_ff @(posedge clk_33) begin
        if (rst || i_flush) begin
            r_done <= '0;
        end else begin
            if (w_hs) begin
                r_done[r_addr[GRP_W-1:0]] <= 1'b1;
            end
            if (i_issue) begin
                r_done[i_issue_addr[GRP_W-1:0]] <= 1'b0;
            end
        end
    end

    // Sticky until reset; idling the scheduler does not clear it.
    always_ff @(posedge clk_33) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (i_start && !w_grp_ready) begin
            r_underflow <= 1'b1;
        end
    end

    assign o_underflow = r_underflow;
`else
    logic w_unused;

    assign w_unused    = &{1'b0, i_start, i_start_grp};
    assign o_underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/segment_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : segment_scheduler
// Description : Timing and fetch scheduler for one LED display segment:
//               a blanking window followed by GROUPS bit groups of GROUP_LEN
//               colour-interleaved (B,G,R) data cycles plus one skip cycle.
//               Prefetches each group's framebuffer word one group ahead.
// Ports       : clk_33, rst   - clock, synchronous active-high reset
//               enable        - run; low returns to IDLE on the next edge
//               sync          - last cycle of the row-0 segment
//               blanking      - IDLE or blanking window
//               data_en       - driver data cycle
//               color_sel     - 0=B, 1=G, 2=R
//               bit_idx       - current bit group
//               mul_idx       - current multiplexing row
//               rd_req/rd_addr/rd_ack - framebuffer fetch handshake
//               underflow     - sticky fetch-late flag
// Config      : SEGMENT_SCHEDULER_UNDERFLOW_EN enables the underflow detector.
// Revision    : 1.0 - initial release
// ============================================================================
module segment_scheduler
    import segment_scheduler_pkg::*;
#(
    parameter int unsigned BLANKING_CYCLES = c_DEF_BLANKING_CYCLES,
    parameter int unsigned GROUP_LEN       = c_DEF_GROUP_LEN,
    parameter int unsigned GROUPS          = c_DEF_GROUPS,
    parameter int unsigned MUL_COUNT       = c_DEF_MUL_COUNT
) (
    input  logic       clk_33,
    input  logic       rst,
    input  logic       enable,
    output logic       sync,
    output logic       blanking,
    output logic       data_en,
    output logic [1:0] color_sel,
    output logic [3:0] bit_idx,
    output logic [2:0] mul_idx,
    output logic       rd_req,
    output logic [6:0] rd_addr,
    input  logic       rd_ack,
    output logic       underflow
);

    localparam int unsigned c_SEG_LEN = seg_len(BLANKING_CYCLES, GROUP_LEN, GROUPS);
    localparam int unsigned c_SEG_W   = $clog2(c_SEG_LEN);
    localparam int unsigned c_POS_W   = $clog2(GROUP_LEN + 1);

    localparam logic [c_SEG_W-1:0] c_SEG_LAST   = c_SEG_W'(c_SEG_LEN - 1);
    localparam logic [c_SEG_W-1:0] c_BLANK_LAST = c_SEG_W'(BLANKING_CYCLES - 1);
    localparam logic [c_SEG_W-1:0] c_SEG_ONE    = c_SEG_W'(1);
    localparam logic [c_POS_W-1:0] c_POS_LAST   = c_POS_W'(GROUP_LEN - 1);
    localparam logic [c_POS_W-1:0] c_POS_ONE    = c_POS_W'(1);
    localparam logic [3:0]         c_GRP_LAST   = 4'(GROUPS - 1);
    localparam logic [2:0]         c_MUL_LAST   = 3'(MUL_COUNT - 1);

    state_t             r_state,     w_nxt_state;
    logic [c_SEG_W-1:0] r_seg_cnt,   w_nxt_seg;
    logic [c_POS_W-1:0] r_grp_pos,   w_nxt_pos;
    logic [3:0]         r_bit_idx,   w_nxt_bit;
    logic [2:0]         r_mul_idx,   w_nxt_mul;
    logic [1:0]         r_color,     w_nxt_color;

    logic               w_enter_seg;
    logic               w_enter_active;
    logic               w_issue;
    logic [6:0]         w_issue_addr;
    logic               w_flush;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_33) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_seg_cnt <= '0;
            r_grp_pos <= '0;
            r_bit_idx <= '0;
            r_mul_idx <= '0;
            r_color   <= COLOR_B;
        end else begin
            r_state   <= w_nxt_state;
            r_seg_cnt <= w_nxt_seg;
            r_grp_pos <= w_nxt_pos;
            r_bit_idx <= w_nxt_bit;
            r_mul_idx <= w_nxt_mul;
            r_color   <= w_nxt_color;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_seg   = r_seg_cnt;
        w_nxt_pos   = r_grp_pos;
        w_nxt_bit   = r_bit_idx;
        w_nxt_mul   = r_mul_idx;
        w_nxt_color = r_color;

        if (!enable) begin
            w_nxt_state = ST_IDLE;
            w_nxt_seg   = '0;
            w_nxt_pos   = '0;
            w_nxt_bit   = '0;
            w_nxt_mul   = '0;
            w_nxt_color = COLOR_B;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = ST_BLANK;
                    w_nxt_seg   = '0;
                end
                ST_BLANK: begin
                    w_nxt_seg = r_seg_cnt + c_SEG_ONE;
                    if (r_seg_cnt == c_BLANK_LAST) begin
                        w_nxt_state = ST_ACTIVE;
                        w_nxt_pos   = '0;
                        w_nxt_color = COLOR_B;
                    end
                end
                ST_ACTIVE: begin
                    w_nxt_seg   = r_seg_cnt + c_SEG_ONE;
                    w_nxt_pos   = r_grp_pos + c_POS_ONE;
                    w_nxt_color = (r_color == COLOR_R) ? COLOR_B : (r_color + 2'd1);
                    if (r_grp_pos == c_POS_LAST) begin
                        w_nxt_state = ST_SKIP;
                        w_nxt_pos   = '0;
                        w_nxt_color = COLOR_B;
                    end
                end
                ST_SKIP: begin
                    if (r_bit_idx == c_GRP_LAST) begin
                        // Segment end: this skip cycle is seg_cnt = SEG_LEN-1
                        w_nxt_state = ST_BLANK;
                        w_nxt_seg   = '0;
                        w_nxt_bit   = '0;
                        w_nxt_mul   = (r_mul_idx == c_MUL_LAST) ? 3'd0 : (r_mul_idx + 3'd1);
                    end else begin
                        w_nxt_state = ST_ACTIVE;
                        w_nxt_seg   = r_seg_cnt + c_SEG_ONE;
                        w_nxt_bit   = r_bit_idx + 4'd1;
                        w_nxt_pos   = '0;
                        w_nxt_color = COLOR_B;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch scheduling: group 0 is requested as the segment's blanking
    // window opens; group g+1 is requested as group g starts its data.
    // Both are decoded from the transition so rd_req rises in the first
    // cycle of the new state.
    // ------------------------------------------------------------------
    assign w_enter_seg    = (w_nxt_state == ST_BLANK)  && (r_state != ST_BLANK);
    assign w_enter_active = (w_nxt_state == ST_ACTIVE) && (r_state != ST_ACTIVE);
    assign w_issue        = w_enter_seg || (w_enter_active && (w_nxt_bit < c_GRP_LAST));
    assign w_issue_addr   = w_enter_seg ? {w_nxt_mul, 4'd0}
                                        : {r_mul_idx, w_nxt_bit + 4'd1};
    assign w_flush        = ~enable;

    segment_fetch_ctrl #(
        .ROW_W (3),
        .GRP_W (4)
    ) u_fetch (
        .clk_33       (clk_33),
        .rst          (rst),
        .i_flush      (w_flush),
        .i_issue      (w_issue),
        .i_issue_addr (w_issue_addr),
        .i_start      (w_enter_active),
        .i_start_grp  (w_nxt_bit),
        .i_rd_ack     (rd_ack),
        .o_rd_req     (rd_req),
        .o_rd_addr    (rd_addr),
        .o_underflow  (underflow)
    );

    // ------------------------------------------------------------------
    // Strobes decoded from registered state
    // ------------------------------------------------------------------
    assign sync      = (r_seg_cnt == c_SEG_LAST) && (r_mul_idx == 3'd0);
    assign blanking  = (r_state == ST_IDLE) || (r_state == ST_BLANK);
    assign data_en   = (r_state == ST_ACTIVE);
    assign color_sel = r_color;
    assign bit_idx   = r_bit_idx;
    assign mul_idx   = r_mul_idx;

endmodule
`default_nettype wire
